task_scheduler: RTL

Round-robin scheduler that shares one execution resource between `NREQ` requesters. Each request carries a job length. The block grants one requester at a time, drives the resource for exactly that many cycles, then reports a completion with an enumerated status. Its control FSM uses the team's standard enum types: `state_t`, `level_t`, `status_t`. It also exports a coarse backlog level for throttling logic upstream.

---
 rtl/task_scheduler_pkg.sv | 34 +++
 rtl/task_scheduler_rr_arbiter.sv | 32 +++
 rtl/task_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/task_scheduler_pkg.sv
// sched_pkg: shared enum types and helpers for the round-robin task scheduler.
package sched_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Coarse backlog level exported to upstream throttling
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    LOW  = 2'd1,
    MED  = 2'd2,
    HIGH = 2'd3
  } level_t;

  // Completion status; ERR is -1 so it reads as 2'b11 on the wire
  typedef enum logic signed [1:0] {
    ERR  = 2'b11,
    OK   = 2'b00,
    WARN = 2'b01
  } status_t;

  // Map a number of pending requesters to a backlog level, saturating at HIGH
  function automatic level_t count_to_level(input int unsigned count);
    if (count == 0)      return OFF;
    else if (count == 1) return LOW;
    else if (count == 2) return MED;
    else                 return HIGH;
  endfunction

endpackage

// File: rtl/task_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The search starts at ptr and
// walks upward with wrap-around; the first asserted request wins.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest offset down to ptr so the nearest request overrides
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/task_scheduler.sv
// task_scheduler: shares one execution resource between NREQ requesters in
// round-robin order. Each accepted job drives run_active for exactly its
// length, then a one-cycle done pulse reports OK / WARN / ERR.
// Optional feature: define TASK_SCHED_ABORT_EN to add the abort input, which
// terminates a running job with status ERR.
module task_scheduler
  import sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 8,
  parameter int WARN_LEN = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*LEN_W-1:0]     req_len,
`ifdef TASK_SCHED_ABORT_EN
  input  logic                      abort,
`endif
  output logic [NREQ-1:0]           req_ready,
  output logic                      run_active,
  output logic [$clog2(NREQ)-1:0]   run_id,
  output logic                      done_valid,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [1:0]                done_status,
  output logic [1:0]                backlog
);

  localparam int IDX_W = $clog2(NREQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [LEN_W-1:0]   r_cnt;
  status_t            r_status;
  logic               r_run_active;
  logic [IDX_W-1:0]   r_run_id;
  logic               r_done_valid;
  logic [IDX_W-1:0]   r_done_id;
  status_t            r_done_status;
  level_t             r_backlog;

  logic [NREQ-1:0]    w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_start;
  logic [LEN_W-1:0]   w_len;
  logic [IDX_W-1:0]   w_ptr_next;
  logic               w_abort;
  level_t             w_level;

`ifdef TASK_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // A grant only happens from IDLE; rst_n gating keeps req_ready low in reset
  assign w_start    = (r_state == IDLE) && w_any;
  assign req_ready  = (w_start && rst_n) ? w_grant : '0;
  assign w_len      = req_len[w_idx*LEN_W +: LEN_W];
  assign w_ptr_next = (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  // The requester granted this cycle no longer counts as backlog
  always_comb begin
    w_level = count_to_level($countones(req_valid & ~req_ready));
  end

  // Control FSM: grant, run the job for its length, report completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_status      <= OK;
      r_run_active  <= 1'b0;
      r_run_id      <= '0;
      r_done_valid  <= 1'b0;
      r_done_id     <= '0;
      r_done_status <= OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ptr <= w_ptr_next;
            if (w_len == '0) begin
              // Zero-length job is rejected without touching the resource
              r_state       <= DONE;
              r_done_valid  <= 1'b1;
              r_done_id     <= w_idx;
              r_done_status <= ERR;
            end else begin
              r_state      <= RUNNING;
              r_cnt        <= w_len;
              r_run_active <= 1'b1;
              r_run_id     <= w_idx;
              if (int'(w_len) > WARN_LEN) r_status <= WARN;
              else                        r_status <= OK;
            end
          end
        end
        RUNNING: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_abort || (r_cnt == LEN_W'(1))) begin
            r_state      <= DONE;
            r_run_active <= 1'b0;
            r_done_valid <= 1'b1;
            r_done_id    <= r_run_id;
            // An abort on the final cycle still reports ERR
            if (w_abort) r_done_status <= ERR;
            else         r_done_status <= r_status;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_done_valid <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_run_active <= 1'b0;
          r_done_valid <= 1'b0;
        end
      endcase
    end
  end

  // Backlog level, registered one cycle behind req_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_backlog <= OFF;
    else        r_backlog <= w_level;
  end

  assign run_active  = r_run_active;
  assign run_id      = r_run_id;
  assign done_valid  = r_done_valid;
  assign done_id     = r_done_id;
  assign done_status = r_done_status;
  assign backlog     = r_backlog;

endmodule
